// File: rtl/gray_track_top.sv
// Gray-code tracker: synchronizes and debounces a 4-bit Gray input, decodes it to binary,
// and classifies each accepted change as a step up, a step down or an illegal jump.
module gray_track_top #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int unsigned CNT_W   = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {INIT, STABLE, SETTLE} state_e;

  logic             clk;
  logic             rst_n;
  logic [3:0]       sw_meta_q, gsync_q;
  logic             clr_meta_q, clr_s_q;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       acc_q, acc_d;
  logic [3:0]       bin_q, bin_d;
  logic [7:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             accept;
  logic [3:0]       new_bin;
  logic [3:0]       delta;
  logic             unused_bits;

  assign clk         = MAX10_CLK1_50;
  assign rst_n       = KEY[0];
  assign unused_bits = ^{SW[9:4], pos_q[7:4]};

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int unsigned i = 0; i < 3; i++) begin
      b[2-i] = b[3-i] ^ g[2-i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      gsync_q    <= '0;
      clr_meta_q <= 1'b0;
      clr_s_q    <= 1'b0;
    end else begin
      sw_meta_q  <= SW[3:0];
      gsync_q    <= sw_meta_q;
      clr_meta_q <= KEY[1];
      clr_s_q    <= clr_meta_q;
    end
  end

  assign new_bin = gray2bin(cand_q);
  assign delta   = new_bin - bin_q;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    err_d   = err_q;
    accept  = 1'b0;

    // A full counter means cand has already been sampled stable DEBOUNCE_CYCLES times,
    // so it takes priority over whatever gsync shows on this edge.
    case (state_q)
      INIT: begin
        if (cnt_q == CNT_MAX) begin
          acc_d   = cand_q;
          bin_d   = new_bin;
          state_d = STABLE;
        end else if (gsync_q != cand_q) begin
          cand_d = gsync_q;
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE: begin
        if (gsync_q != acc_q) begin
          cand_d  = gsync_q;
          cnt_d   = CNT_W'(1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_MAX) begin
          accept  = 1'b1;
          acc_d   = cand_q;
          bin_d   = new_bin;
          state_d = STABLE;
        end else if (gsync_q == acc_q) begin
          state_d = STABLE;
        end else if (gsync_q != cand_q) begin
          cand_d = gsync_q;
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = INIT;
    endcase

    if (accept) begin
      if (delta == 4'd1) begin
        pos_d = pos_q + 8'd1;
        dir_d = 1'b1;
      end else if (delta == 4'hF) begin
        pos_d = pos_q - 8'd1;
        dir_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (!clr_s_q) begin
      pos_d = '0;
      err_d = 1'b0;
      dir_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cand_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign LEDR = {err_q, dir_q, pos_q[3:0], bin_q};

endmodule

// File: tb/tb_gray_track_top.sv
// Directed bench for gray_track_top with DEBOUNCE_CYCLES = 4; LEDR = {err, dir, pos[3:0], bin}.
module tb_gray_track_top;

  logic       clk;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  int unsigned n_cmp;
  int unsigned n_bad;

  gray_track_top #(.DEBOUNCE_CYCLES(4)) dut (
    .MAX10_CLK1_50 (clk),
    .KEY           (key),
    .SW            (sw),
    .LEDR          (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_with(input logic [3:0] g);
    key[0] = 1'b0;
    sw     = {6'b101010, g};
    step(2);
    check("in_reset", ledr, 10'h100);
    key[0] = 1'b1;
    step(10);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    key   = 2'b11;
    sw    = '0;
    step(1);

    // Baseline 0110 -> binary 4
    reset_with(4'b0110);
    check("baseline", ledr, 10'h104);

    // Exact latency 2 + 4 + 1 edges: 0110 -> 0111 (bin 5, step up)
    sw[3:0] = 4'b0111;
    step(6);
    check("latency_before", ledr, 10'h104);
    step(1);
    check("latency_at", ledr, 10'h115);

    // Counting up
    reset_with(4'b0000);
    check("up_base", ledr, 10'h100);
    sw[3:0] = 4'b0001; step(10);
    check("up_1", ledr, 10'h111);
    sw[3:0] = 4'b0011; step(10);
    check("up_2", ledr, 10'h122);
    sw[3:0] = 4'b0010; step(10);
    check("up_3", ledr, 10'h133);

    // Down wrap 0 -> 255, then up wrap 255 -> 0
    reset_with(4'b0000);
    sw[3:0] = 4'b1000; step(10);
    check("down_wrap", ledr, 10'h0FF);
    sw[3:0] = 4'b0000; step(10);
    check("up_wrap", ledr, 10'h100);

    // Illegal jump 0000 -> 0011, then clear pulse
    reset_with(4'b0000);
    sw[3:0] = 4'b0011; step(10);
    check("illegal", ledr, 10'h302);
    key[1] = 1'b0;
    step(2);
    check("clr_before", ledr, 10'h302);
    step(1);
    check("clr_at", ledr, 10'h102);
    key[1] = 1'b1;
    step(10);
    check("clr_after", ledr, 10'h102);

    // Glitch rejection from 0001
    reset_with(4'b0001);
    check("glitch_base", ledr, 10'h101);
    sw[3:0] = 4'b0011; step(2);
    sw[3:0] = 4'b0001; step(10);
    check("glitch_2cyc", ledr, 10'h101);
    sw[3:0] = 4'b0011; step(5);
    sw[3:0] = 4'b0001; step(3);
    check("pulse_accept", ledr, 10'h112);
    step(10);
    check("pulse_back", ledr, 10'h001);

    // Reset while in SETTLE toward 0101 (bin 6)
    sw[3:0] = 4'b0101; step(4);
    check("pre_reset", ledr, 10'h001);
    key[0] = 1'b0;
    #1;
    check("async_reset", ledr, 10'h100);
    step(2);
    key[0] = 1'b1;
    step(10);
    check("rebaseline", ledr, 10'h106);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
